// File: rtl/core_seq.sv
// Multi-cycle sequencer for a simple in-order core: fetch, decode, execute, memory, writeback.
// Decode and execute logic live outside; this block owns state, PC, handshakes and retirement.
module core_seq #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned     REG_AW   = 5,
  parameter int unsigned     CNT_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  // Instruction memory
  output logic              imem_req,
  output logic [XLEN-1:0]   imem_addr,
  input  logic              imem_ready,
  input  logic [31:0]       imem_rdata,
  // Decoder
  output logic [31:0]       instr_q,
  input  logic              dec_is_load,
  input  logic              dec_is_store,
  input  logic              dec_is_branch,
  input  logic              dec_is_jump,
  input  logic              dec_is_alu,
  input  logic              dec_illegal,
  input  logic [REG_AW-1:0] dec_dest,
  // Execute unit
  input  logic [XLEN-1:0]   ex_result,
  input  logic [XLEN-1:0]   ex_next_pc,
  input  logic              ex_taken,
  // Data memory
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [XLEN-1:0]   dmem_addr,
  input  logic              dmem_ready,
  input  logic [XLEN-1:0]   dmem_rdata,
  // Register file write port
  output logic              rf_wen,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [XLEN-1:0]   rf_wdata,
  // Status
  output logic [XLEN-1:0]   pc,
  output logic              trap,
  output logic [CNT_W-1:0]  instret
);

  typedef enum logic [2:0] {
    StFetch,
    StDecode,
    StExecute,
    StMem,
    StWb,
    StTrap
  } state_e;

  state_e state_q, state_d;

  logic [XLEN-1:0]   pc_q, pc_d;
  logic [CNT_W-1:0]  instret_q, instret_d;
  logic [31:0]       instr_d;

  // Fields captured in DECODE
  logic              ld_q, ld_d;
  logic              st_q, st_d;
  logic              br_q, br_d;
  logic              jmp_q, jmp_d;
  logic              alu_q, alu_d;
  logic [REG_AW-1:0] dest_q, dest_d;

  // Fields captured in EXECUTE
  logic [XLEN-1:0]   res_q, res_d;
  logic [XLEN-1:0]   tgt_q, tgt_d;
  logic              redir_q, redir_d;

  // Registered outputs
  logic              imem_req_q, imem_req_d;
  logic              dmem_req_q, dmem_req_d;
  logic              dmem_we_q, dmem_we_d;
  logic              rf_wen_q, rf_wen_d;
  logic [REG_AW-1:0] rf_waddr_q, rf_waddr_d;
  logic [XLEN-1:0]   rf_wdata_q, rf_wdata_d;
  logic              trap_q, trap_d;

  logic [XLEN-1:0]   pc_plus4;
  logic              wr_ok;

  assign pc_plus4 = pc_q + XLEN'(4);
  // Register 0 is hardwired, so a write to it is dropped here rather than in the file.
  assign wr_ok    = (alu_q | ld_q | jmp_q) && (dest_q != '0);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instret_d  = instret_q;
    instr_d    = instr_q;
    ld_d       = ld_q;
    st_d       = st_q;
    br_d       = br_q;
    jmp_d      = jmp_q;
    alu_d      = alu_q;
    dest_d     = dest_q;
    res_d      = res_q;
    tgt_d      = tgt_q;
    redir_d    = redir_q;
    rf_wen_d   = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;

    unique case (state_q)
      StFetch: begin
        // Only a ready seen while the request is actually out counts.
        if (imem_req_q && imem_ready) begin
          instr_d = imem_rdata;
          state_d = StDecode;
        end
      end

      StDecode: begin
        ld_d    = dec_is_load;
        st_d    = dec_is_store;
        br_d    = dec_is_branch;
        jmp_d   = dec_is_jump;
        alu_d   = dec_is_alu;
        dest_d  = dec_dest;
        state_d = dec_illegal ? StTrap : StExecute;
      end

      StExecute: begin
        res_d   = ex_result;
        tgt_d   = ex_next_pc;
        redir_d = (ex_taken & br_q) | jmp_q;
        if (redir_d && (ex_next_pc[1:0] != 2'b00)) begin
          state_d = StTrap;
        end else if (ld_q | st_q) begin
          state_d = StMem;
        end else begin
          state_d    = StWb;
          rf_wen_d   = wr_ok;
          rf_waddr_d = dest_q;
          rf_wdata_d = jmp_q ? pc_plus4 : ex_result;
        end
      end

      StMem: begin
        if (dmem_req_q && dmem_ready) begin
          state_d    = StWb;
          rf_wen_d   = wr_ok;
          rf_waddr_d = dest_q;
          rf_wdata_d = ld_q ? dmem_rdata : (jmp_q ? pc_plus4 : res_q);
        end
      end

      StWb: begin
        pc_d      = redir_q ? tgt_q : pc_plus4;
        instret_d = instret_q + CNT_W'(1);
        state_d   = StFetch;
      end

      StTrap: begin
        state_d = StTrap;
      end

      default: begin
        state_d = StTrap;
      end
    endcase

    // Requests are decided one cycle ahead so they come straight out of flops.
    imem_req_d = (state_d == StFetch);
    dmem_req_d = (state_d == StMem);
    dmem_we_d  = (state_d == StMem) & st_q;
    trap_d     = (state_d == StTrap);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StFetch;
      pc_q       <= RESET_PC;
      instret_q  <= '0;
      instr_q    <= '0;
      ld_q       <= 1'b0;
      st_q       <= 1'b0;
      br_q       <= 1'b0;
      jmp_q      <= 1'b0;
      alu_q      <= 1'b0;
      dest_q     <= '0;
      res_q      <= '0;
      tgt_q      <= '0;
      redir_q    <= 1'b0;
      imem_req_q <= 1'b0;
      dmem_req_q <= 1'b0;
      dmem_we_q  <= 1'b0;
      rf_wen_q   <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      trap_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instret_q  <= instret_d;
      instr_q    <= instr_d;
      ld_q       <= ld_d;
      st_q       <= st_d;
      br_q       <= br_d;
      jmp_q      <= jmp_d;
      alu_q      <= alu_d;
      dest_q     <= dest_d;
      res_q      <= res_d;
      tgt_q      <= tgt_d;
      redir_q    <= redir_d;
      imem_req_q <= imem_req_d;
      dmem_req_q <= dmem_req_d;
      dmem_we_q  <= dmem_we_d;
      rf_wen_q   <= rf_wen_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      trap_q     <= trap_d;
    end
  end

  assign imem_req  = imem_req_q;
  assign imem_addr = pc_q;
  assign dmem_req  = dmem_req_q;
  assign dmem_we   = dmem_we_q;
  assign dmem_addr = res_q;
  assign rf_wen    = rf_wen_q;
  assign rf_waddr  = rf_waddr_q;
  assign rf_wdata  = rf_wdata_q;
  assign pc        = pc_q;
  assign trap      = trap_q;
  assign instret   = instret_q;

endmodule

// File: tb/tb_core_seq.sv
// Directed bench for core_seq: drives decoder/execute/memory responses and scoreboards
// register-file writes against expectations queued when each instruction is set up.
module tb_core_seq;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              imem_req;
  logic [XLEN-1:0]   imem_addr;
  logic              imem_ready = 1'b0;
  logic [31:0]       imem_rdata = '0;
  logic [31:0]       instr_q;
  logic              dec_is_load = 1'b0, dec_is_store = 1'b0, dec_is_branch = 1'b0;
  logic              dec_is_jump = 1'b0, dec_is_alu = 1'b0, dec_illegal = 1'b0;
  logic [4:0]        dec_dest = '0;
  logic [XLEN-1:0]   ex_result = '0, ex_next_pc = '0;
  logic              ex_taken = 1'b0;
  logic              dmem_req, dmem_we;
  logic [XLEN-1:0]   dmem_addr;
  logic              dmem_ready = 1'b0;
  logic [XLEN-1:0]   dmem_rdata = '0;
  logic              rf_wen;
  logic [4:0]        rf_waddr;
  logic [XLEN-1:0]   rf_wdata;
  logic [XLEN-1:0]   pc;
  logic              trap;
  logic [CNT_W-1:0]  instret;

  core_seq #(
    .XLEN    (XLEN),
    .RESET_PC('0),
    .REG_AW  (5),
    .CNT_W   (CNT_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ready   (imem_ready),
    .imem_rdata   (imem_rdata),
    .instr_q      (instr_q),
    .dec_is_load  (dec_is_load),
    .dec_is_store (dec_is_store),
    .dec_is_branch(dec_is_branch),
    .dec_is_jump  (dec_is_jump),
    .dec_is_alu   (dec_is_alu),
    .dec_illegal  (dec_illegal),
    .dec_dest     (dec_dest),
    .ex_result    (ex_result),
    .ex_next_pc   (ex_next_pc),
    .ex_taken     (ex_taken),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .dmem_addr    (dmem_addr),
    .dmem_ready   (dmem_ready),
    .dmem_rdata   (dmem_rdata),
    .rf_wen       (rf_wen),
    .rf_waddr     (rf_waddr),
    .rf_wdata     (rf_wdata),
    .pc           (pc),
    .trap         (trap),
    .instret      (instret)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  checks = 0;
  int  errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Every register-file write must match the oldest queued expectation.
  always @(negedge clk) begin
    if (reset === 1'b0 && rf_wen === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("rf_unexpected_wen", rf_wen, 1'b0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("rf_waddr", rf_waddr, mon_e.a);
        chk("rf_wdata", rf_wdata, mon_e.d);
      end
    end
  end

  task automatic push_wr(input logic [4:0] a, input logic [31:0] d);
    wr_t e;
    e.a = a;
    e.d = d;
    exp_q.push_back(e);
  endtask

  task automatic set_dec(input bit ld, input bit st, input bit br, input bit jmp, input bit alu,
                         input bit ill, input logic [4:0] dest, input logic [31:0] res,
                         input logic [31:0] tgt, input bit tk);
    dec_is_load = ld; dec_is_store = st; dec_is_branch = br; dec_is_jump = jmp;
    dec_is_alu = alu; dec_illegal = ill; dec_dest = dest;
    ex_result = res; ex_next_pc = tgt; ex_taken = tk;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_imem_req"}, imem_req, 1'b0);
    chk({tag, "_dmem_req"}, dmem_req, 1'b0);
    chk({tag, "_dmem_we"}, dmem_we, 1'b0);
    chk({tag, "_rf_wen"}, rf_wen, 1'b0);
    chk({tag, "_trap"}, trap, 1'b0);
    chk({tag, "_pc"}, pc, 32'h0);
    chk({tag, "_instr_q"}, instr_q, 32'h0);
    chk({tag, "_instret"}, instret, 4'h0);
    chk({tag, "_rf_waddr"}, rf_waddr, 5'h0);
    chk({tag, "_rf_wdata"}, rf_wdata, 32'h0);
    chk({tag, "_dmem_addr"}, dmem_addr, 32'h0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk_reset("rst");
    reset = 1'b0;
    @(negedge clk);
    chk("first_imem_req", imem_req, 1'b1);
  endtask

  // Wait (bounded) for a fetch request, answer it, and return in the DECODE cycle.
  task automatic fetch(input logic [31:0] pc_exp);
    int n = 0;
    logic [31:0] w;
    while (imem_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("fetch_req", imem_req, 1'b1);
    chk("fetch_addr", imem_addr, pc_exp);
    w = $urandom;
    imem_rdata = w;
    imem_ready = 1'b1;
    @(negedge clk);
    imem_ready = 1'b0;
    chk("instr_q", instr_q, w);
  endtask

  // Run one whole instruction; any data access is answered after wait_n stall cycles.
  task automatic run(input logic [31:0] pc_exp, input int wait_n, input bit we_exp);
    int n = 0;
    int s = 0;
    fetch(pc_exp);
    while (imem_req !== 1'b1 && trap !== 1'b1 && n < 40) begin
      if (dmem_req === 1'b1) begin
        chk("mem_we", dmem_we, we_exp);
        dmem_ready = (s == wait_n);
        s++;
      end else begin
        dmem_ready = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    dmem_ready = 1'b0;
    chk("instr_done", imem_req, 1'b1);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] r;
    logic        seen;

    do_reset();

    // ALU write to x3, with cycle-accurate checks of the 4-cycle sequence.
    set_dec(0, 0, 0, 0, 1, 0, 5'd3, 32'h42, 32'h0, 0);
    push_wr(5'd3, 32'h42);
    fetch(32'h0);
    @(negedge clk);
    chk("alu_exec_no_wen", rf_wen, 1'b0);
    @(negedge clk);
    chk("alu_wb_wen", rf_wen, 1'b1);
    @(negedge clk);
    chk("alu_pc", pc, 32'h4);
    chk("alu_instret", instret, 4'd1);
    chk("alu_wen_pulse", rf_wen, 1'b0);
    chk("alu_refetch", imem_req, 1'b1);

    // Load with three stall cycles; an early dmem_ready outside MEM is ignored.
    set_dec(1, 0, 0, 0, 0, 0, 5'd5, 32'h200, 32'h0, 0);
    dmem_rdata = 32'hDEAD_BEEF;
    push_wr(5'd5, 32'hDEAD_BEEF);
    fetch(32'h4);
    dmem_ready = 1'b1;
    @(negedge clk);
    dmem_ready = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk("ld_req_held", dmem_req, 1'b1);
      chk("ld_addr_stable", dmem_addr, 32'h200);
      chk("ld_we", dmem_we, 1'b0);
      if (i == 3) dmem_ready = 1'b1;
      @(negedge clk);
    end
    dmem_ready = 1'b0;
    chk("ld_req_drop", dmem_req, 1'b0);
    chk("ld_wdata", rf_wdata, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("ld_pc", pc, 32'h8);
    chk("ld_instret", instret, 4'd2);

    // Store (no write-back), then ALU to x0 (suppressed).
    set_dec(0, 1, 0, 0, 0, 0, 5'd0, 32'h300, 32'h0, 0);
    run(32'h8, 0, 1'b1);
    chk("st_pc", pc, 32'hC);
    set_dec(0, 0, 0, 0, 1, 0, 5'd0, 32'h77, 32'h0, 0);
    run(32'hC, 0, 1'b0);
    chk("alu_x0_pc", pc, 32'h10);

    // Jumps: link to x1, back again via x2, then the same jump with dest=0.
    set_dec(0, 0, 0, 1, 0, 0, 5'd1, 32'h0, 32'h100, 0);
    push_wr(5'd1, 32'h14);
    run(32'h10, 0, 1'b0);
    chk("jmp_pc", pc, 32'h100);
    set_dec(0, 0, 0, 1, 0, 0, 5'd2, 32'h0, 32'h10, 0);
    push_wr(5'd2, 32'h104);
    run(32'h100, 0, 1'b0);
    chk("jmp_back_pc", pc, 32'h10);
    set_dec(0, 0, 0, 1, 0, 0, 5'd0, 32'h0, 32'h100, 0);
    run(32'h10, 0, 1'b0);
    chk("jmp_x0_pc", pc, 32'h100);

    // Not-taken branch to a misaligned target does not trap; taken aligned branch redirects.
    set_dec(0, 0, 1, 0, 0, 0, 5'd0, 32'h0, 32'h102, 0);
    run(32'h100, 0, 1'b0);
    chk("br_nt_pc", pc, 32'h104);
    chk("br_nt_trap", trap, 1'b0);
    set_dec(0, 0, 1, 0, 0, 0, 5'd0, 32'h0, 32'h200, 1);
    run(32'h104, 0, 1'b0);
    chk("br_t_pc", pc, 32'h200);
    chk("br_t_instret", instret, 4'd9);

    // Seven more retires bring the 4-bit counter to 16, i.e. wrap to 0.
    for (int i = 0; i < 7; i++) begin
      r = $urandom;
      set_dec(0, 0, 0, 0, 1, 0, 5'(i + 8), r, 32'h0, 0);
      push_wr(5'(i + 8), r);
      run(32'h200 + 32'(4 * i), 0, 1'b0);
    end
    chk("wrap_instret", instret, 4'd0);
    chk("wrap_pc", pc, 32'h21C);

    // Taken branch to a misaligned target traps with pc frozen and no further fetch.
    set_dec(0, 0, 1, 0, 0, 0, 5'd0, 32'h0, 32'h102, 1);
    fetch(32'h21C);
    @(negedge clk);
    @(negedge clk);
    chk("mis_trap", trap, 1'b1);
    chk("mis_pc", pc, 32'h21C);
    seen = 1'b0;
    imem_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      seen = seen | imem_req | dmem_req | rf_wen;
      @(negedge clk);
    end
    imem_ready = 1'b0;
    chk("mis_no_req", seen, 1'b0);
    chk("mis_trap_held", trap, 1'b1);
    chk("mis_pc_held", pc, 32'h21C);
    chk("mis_instret_held", instret, 4'd0);

    // Illegal instruction traps straight after DECODE.
    do_reset();
    set_dec(0, 0, 0, 0, 1, 1, 5'd4, 32'h1, 32'h0, 0);
    fetch(32'h0);
    @(negedge clk);
    chk("ill_trap", trap, 1'b1);
    chk("ill_no_fetch", imem_req, 1'b0);
    chk("ill_pc", pc, 32'h0);

    // Reset in the middle of a stalled load aborts it with no write.
    do_reset();
    set_dec(1, 0, 0, 0, 0, 0, 5'd7, 32'h40, 32'h0, 0);
    fetch(32'h0);
    @(negedge clk);
    @(negedge clk);
    chk("stall_req", dmem_req, 1'b1);
    chk("stall_addr", dmem_addr, 32'h40);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk_reset("mid_mem");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("post_rst_instret", instret, 4'd0);
    chk("post_rst_pc", pc, 32'h0);
    chk("post_rst_req", imem_req, 1'b1);

    chk("sb_drain", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
